// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - ALU control decoder with handshake and multi-cycle MULT/DIV sequencing
// Single-cycle codes go straight to OUT; MULT/DIV wait in MULTI for their latency first.
module alu_control_mc #(
    parameter int CODE_WIDTH = 4,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 8,
    parameter bit EN_MULDIV  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            alu_op_i,
    input  logic [5:0]            alu_function_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [CODE_WIDTH-1:0] alu_operation_o,
    output logic                  busy_o,
    output logic                  multicycle_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

    typedef enum logic [1:0] {S_IDLE, S_MULTI, S_OUT} state_t;

    state_t                r_state, w_state_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic [CODE_WIDTH-1:0] r_code, w_code_nx;
    logic [CODE_WIDTH-1:0] r_pend, w_pend_nx;
    logic                  r_mc, w_mc_nx;

    logic [3:0]            w_dec;
    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_load;

    always_comb begin
        w_dec    = 4'd9;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (alu_op_i)
            3'b111: begin
                case (alu_function_i)
                    6'b100010: w_dec = 4'd1;
                    6'b100101: w_dec = 4'd2;
                    6'b100000: w_dec = 4'd3;
                    6'b000000: w_dec = 4'd5;
                    6'b000010: w_dec = 4'd6;
                    6'b100100: w_dec = 4'd7;
                    6'b100111: w_dec = 4'd8;
                    6'b001000: w_dec = 4'hA;
                    6'b011000: begin
                        if (EN_MULDIV) begin
                            w_dec    = 4'hB;
                            w_is_mul = 1'b1;
                        end
                    end
                    6'b011010: begin
                        if (EN_MULDIV) begin
                            w_dec    = 4'hC;
                            w_is_div = 1'b1;
                        end
                    end
                    default: w_dec = 4'd9;
                endcase
            end
            3'b100:  w_dec = 4'd3;
            3'b001:  w_dec = 4'd4;
            3'b010:  w_dec = 4'd2;
            3'b011:  w_dec = 4'd7;
            3'b101:  w_dec = 4'd3;
            3'b110:  w_dec = 4'd1;
            default: w_dec = 4'd9;
        endcase
    end

    assign ready_o    = (r_state == S_IDLE) || ((r_state == S_OUT) && ready_i);
    assign w_accept   = valid_i && ready_o;
    assign w_cnt_load = w_is_mul ? CNT_W'(MUL_LAT - 2) : CNT_W'(DIV_LAT - 2);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_code_nx  = r_code;
        w_pend_nx  = r_pend;
        w_mc_nx    = r_mc;
        case (r_state)
            S_IDLE, S_OUT: begin
                if (w_accept) begin
                    w_mc_nx = 1'b0;
                    if (w_is_mul || w_is_div) begin
                        w_state_nx = S_MULTI;
                        w_cnt_nx   = w_cnt_load;
                        w_pend_nx  = CODE_WIDTH'(w_dec);
                    end else begin
                        w_state_nx = S_OUT;
                        w_code_nx  = CODE_WIDTH'(w_dec);
                    end
                end else if ((r_state == S_OUT) && ready_i) begin
                    w_state_nx = S_IDLE;
                    w_mc_nx    = 1'b0;
                end
            end
            S_MULTI: begin
                // The pending code is only exposed once the latency has elapsed
                if (r_cnt == '0) begin
                    w_state_nx = S_OUT;
                    w_code_nx  = r_pend;
                    w_mc_nx    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= CODE_WIDTH'(4'd9);
            r_pend  <= CODE_WIDTH'(4'd9);
            r_mc    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_code  <= w_code_nx;
            r_pend  <= w_pend_nx;
            r_mc    <= w_mc_nx;
        end
    end

    assign valid_o         = (r_state == S_OUT);
    assign busy_o          = (r_state == S_MULTI);
    assign multicycle_o    = r_mc;
    assign alu_operation_o = r_code;

endmodule

// File: tb/tb_alu_control_mc.sv
// tb/tb_alu_control_mc.sv - randomized and directed bench for alu_control_mc against a behavioural model
// Instance 0 uses defaults; instance 1 has MULT/DIV disabled.
module tb_alu_control_mc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] alu_op = 3'd0;
    logic [5:0] funct = 6'd0;
    logic       vin = 1'b0;
    logic       rdy_in = 1'b1;

    logic [1:0] o_rdy, o_vld, o_busy, o_mc;
    logic [3:0] o_code [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit saw_c = 1'b0;
    bit saw_busy1 = 1'b0;
    int cyc = 0;

    // behavioural model state, one entry per instance
    bit m_valid [2];
    bit m_busy  [2];
    bit m_mc    [2];
    int m_code  [2];
    int m_pend  [2];
    int m_due   [2];

    always #5 clk = ~clk;

    alu_control_mc dut0 (
        .clk(clk), .reset(reset), .alu_op_i(alu_op), .alu_function_i(funct),
        .valid_i(vin), .ready_o(o_rdy[0]), .ready_i(rdy_in), .valid_o(o_vld[0]),
        .alu_operation_o(o_code[0]), .busy_o(o_busy[0]), .multicycle_o(o_mc[0])
    );

    alu_control_mc #(.EN_MULDIV(1'b0)) dut1 (
        .clk(clk), .reset(reset), .alu_op_i(alu_op), .alu_function_i(funct),
        .valid_i(vin), .ready_o(o_rdy[1]), .ready_i(rdy_in), .valid_o(o_vld[1]),
        .alu_operation_o(o_code[1]), .busy_o(o_busy[1]), .multicycle_o(o_mc[1])
    );

    function automatic void ref_decode(input int op, input int fn, input bit en,
                                       output int code, output int lat);
        code = 9;
        lat  = 1;
        if (op == 7) begin
            if (fn == 'h22) code = 1;
            else if (fn == 'h25) code = 2;
            else if (fn == 'h20) code = 3;
            else if (fn == 'h00) code = 5;
            else if (fn == 'h02) code = 6;
            else if (fn == 'h24) code = 7;
            else if (fn == 'h27) code = 8;
            else if (fn == 'h08) code = 10;
            else if (fn == 'h18 && en) begin code = 11; lat = 4; end
            else if (fn == 'h1A && en) begin code = 12; lat = 8; end
        end else if (op == 4 || op == 5) code = 3;
        else if (op == 1) code = 4;
        else if (op == 2) code = 2;
        else if (op == 3) code = 7;
        else if (op == 6) code = 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit mrdy;
            int c, l;
            mrdy = !m_busy[k] && (!m_valid[k] || rdy_in);
            if (reset) begin
                m_valid[k] = 0; m_busy[k] = 0; m_mc[k] = 0; m_code[k] = 9; m_pend[k] = 9;
            end else if (m_busy[k]) begin
                if (cyc == m_due[k]) begin
                    m_busy[k] = 0; m_valid[k] = 1; m_mc[k] = 1; m_code[k] = m_pend[k];
                end
            end else if (vin && mrdy) begin
                ref_decode(int'(alu_op), int'(funct), (k == 0), c, l);
                m_mc[k] = 0;
                if (l == 1) begin
                    m_valid[k] = 1; m_code[k] = c;
                end else begin
                    m_valid[k] = 0; m_busy[k] = 1; m_pend[k] = c; m_due[k] = cyc + l - 1;
                end
            end else if (m_valid[k] && rdy_in) begin
                m_valid[k] = 0; m_mc[k] = 0;
            end
        end
        if (reset) chk_en = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_ready%0d", k), 32'(o_rdy[k]),
                    32'(!m_busy[k] && (!m_valid[k] || rdy_in)));
                chk($sformatf("model_valid%0d", k), 32'(o_vld[k]), 32'(m_valid[k]));
                chk($sformatf("model_busy%0d", k), 32'(o_busy[k]), 32'(m_busy[k]));
                chk($sformatf("model_mc%0d", k), 32'(o_mc[k]), 32'(m_mc[k]));
                chk($sformatf("model_code%0d", k), 32'(o_code[k]), 32'(m_code[k]));
            end
            if (o_code[0] == 4'hC) saw_c = 1'b1;
            if (o_busy[1] === 1'b1) saw_busy1 = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [5:0] fn);
        vin = 1'b1; alu_op = op; funct = fn;
        step();
        vin = 1'b0;
    endtask

    logic [5:0] fn_tab [10];

    initial begin
        fn_tab = '{6'h22, 6'h25, 6'h20, 6'h00, 6'h02, 6'h24, 6'h27, 6'h08, 6'h18, 6'h1A};
        step(); step();
        reset = 1'b0;
        chk("rst_ready", 32'(o_rdy[0]), 32'd1);
        chk("rst_valid", 32'(o_vld[0]), 32'd0);
        chk("rst_code", 32'(o_code[0]), 32'd9);

        req(3'b111, 6'b100010);
        chk("sub_valid", 32'(o_vld[0]), 32'd1);
        chk("sub_code", 32'(o_code[0]), 32'd1);
        chk("sub_mc", 32'(o_mc[0]), 32'd0);

        vin = 1'b1; alu_op = 3'b100; step();
        chk("b2b_addi", 32'(o_code[0]), 32'd3);
        chk("b2b_valid0", 32'(o_vld[0]), 32'd1);
        alu_op = 3'b001; step();
        chk("b2b_lui", 32'(o_code[0]), 32'd4);
        chk("b2b_valid1", 32'(o_vld[0]), 32'd1);
        alu_op = 3'b011; step();
        chk("b2b_andi", 32'(o_code[0]), 32'd7);
        chk("b2b_valid2", 32'(o_vld[0]), 32'd1);
        vin = 1'b0; step();

        req(3'b111, 6'b011000);
        for (int i = 0; i < 3; i++) begin
            chk("mul_busy", 32'(o_busy[0]), 32'd1);
            chk("mul_ready", 32'(o_rdy[0]), 32'd0);
            chk("mul_valid_low", 32'(o_vld[0]), 32'd0);
            step();
        end
        chk("mul_valid", 32'(o_vld[0]), 32'd1);
        chk("mul_code", 32'(o_code[0]), 32'hB);
        chk("mul_mc", 32'(o_mc[0]), 32'd1);
        chk("mul_busy_done", 32'(o_busy[0]), 32'd0);
        step();

        rdy_in = 1'b0;
        req(3'b111, 6'b100101);
        for (int i = 0; i < 5; i++) begin
            chk("or_hold_valid", 32'(o_vld[0]), 32'd1);
            chk("or_hold_code", 32'(o_code[0]), 32'd2);
            chk("or_hold_ready", 32'(o_rdy[0]), 32'd0);
            step();
        end
        rdy_in = 1'b1;
        #1;
        chk("or_release_ready", 32'(o_rdy[0]), 32'd1);
        step();
        chk("or_idle_valid", 32'(o_vld[0]), 32'd0);
        chk("or_idle_mc", 32'(o_mc[0]), 32'd0);
        chk("or_keep_code", 32'(o_code[0]), 32'd2);

        saw_c = 1'b0;
        req(3'b111, 6'b011010);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("div_abort_valid", 32'(o_vld[0]), 32'd0);
        chk("div_abort_busy", 32'(o_busy[0]), 32'd0);
        chk("div_abort_code", 32'(o_code[0]), 32'd9);
        repeat (12) step();
        chk("div_abort_no_c", 32'(saw_c), 32'd0);

        req(3'b111, 6'b011010);
        chk("nomd_div_valid", 32'(o_vld[1]), 32'd1);
        chk("nomd_div_code", 32'(o_code[1]), 32'd9);
        chk("nomd_div_busy", 32'(o_busy[1]), 32'd0);
        repeat (8) step();
        req(3'b000, 6'(($urandom)));
        chk("nomd_op0_valid", 32'(o_vld[1]), 32'd1);
        chk("nomd_op0_code", 32'(o_code[1]), 32'd9);
        chk("dflt_op0_code", 32'(o_code[0]), 32'd9);

        for (int n = 0; n < 4000; n++) begin
            int idx;
            idx    = $urandom_range(0, 13);
            reset  = ($urandom_range(0, 99) == 0);
            vin    = ($urandom_range(0, 3) != 0);
            alu_op = 3'($urandom);
            if (idx < 10) alu_op = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
            funct  = (idx < 10) ? fn_tab[idx] : 6'($urandom);
            rdy_in = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; vin = 1'b0;
        step();
        chk("nomd_never_busy", 32'(saw_busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
